// File: rtl/uart_tx_frame_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_tx_frame_ctrl_if                                      |
// | Brief   : Byte handshake bundle between byte source and frame ctrl.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_tx_frame_ctrl_if;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       data_ready;
  logic       PAR_EN;
  logic       PAR_TYP;

  modport master (
    output P_Data,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  data_ready
  );

  modport slave (
    input  P_Data,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output data_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_tx_frame_ctrl                                         |
// | Brief   : UART TX frame controller: start/data/parity/stop sequencing|
// |           and serializer control. Parity via UART_TX_PARITY_EN.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_frame_ctrl (
  input  wire logic             clk,
  input  wire logic             rst,
  uart_tx_frame_ctrl_if.slave   byte_if,
  input  wire logic             ser_data,
  input  wire logic             ser_done,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  frame_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       w_ready;
  logic       w_accept;
  logic       w_last_data;

`ifdef UART_TX_PARITY_EN
  logic par_bit_q;
  logic par_en_q;
`else
  logic w_unused_par;
  assign w_unused_par = ^{byte_if.P_Data, byte_if.PAR_EN, byte_if.PAR_TYP};
`endif

  assign w_ready            = (state_q == S_IDLE) || (state_q == S_STOP);
  assign w_accept           = byte_if.Data_Valid & w_ready;
  assign w_last_data        = (cnt_q == 4'd7);
  assign byte_if.data_ready = w_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_STOP: state_d = w_accept ? S_START : S_IDLE;
      S_START: begin
        state_d = S_DATA;
        cnt_d   = 4'd0;
      end
      S_DATA: begin
        cnt_d = cnt_q + 4'd1;
        // The counter defines frame timing; ser_done is only cross-checked.
        err_d = w_last_data ? ~ser_done : ser_done;
        if (w_last_data) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: state_d = S_STOP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef UART_TX_PARITY_EN
      if (w_accept) begin
        par_bit_q <= (^byte_if.P_Data) ^ byte_if.PAR_TYP;
        par_en_q  <= byte_if.PAR_EN;
      end
`endif
    end
  end

  assign busy      = (state_q == S_START) || (state_q == S_DATA);
  assign ser_en    = busy | w_accept;
  assign frame_err = err_q;

  always_comb begin
    TX_OUT = 1'b1;
    case (state_q)
      S_START:  TX_OUT = 1'b0;
      S_DATA:   TX_OUT = ser_data;
`ifdef UART_TX_PARITY_EN
      S_PARITY: TX_OUT = par_bit_q;
`endif
      default:  TX_OUT = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame_ctrl.md
# uart_tx_frame_ctrl

- Frame controller of the UART transmitter.
- Accepts a byte with a valid/ready handshake and drives the serializer's `ser_en`/`busy` controls.
- Computes the parity bit and multiplexes start, data, parity and stop bits onto the serial line `TX_OUT`.
- Sits directly upstream of the serializer and consumes its `ser_data`/`ser_done`. `clk` is the bit clock: one frame bit per cycle.

## Interface
Parameters:
- none; frame format is 1 start, 8 data (LSB first), optional parity, 1 stop.

Ports:
- `clk` in 1: bit clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `P_Data` in 8: byte to send. The same bus feeds the serializer's load input. Must be stable in the accept cycle.
- `Data_Valid` in 1: byte offered.
- `data_ready` out 1: byte can be accepted this cycle.
- `PAR_EN` in 1: parity bit in frame. Sampled at accept.
- `PAR_TYP` in 1: 0 = even, 1 = odd. Sampled at accept.
- `ser_data` in 1: registered serial bit from the serializer.
- `ser_done` in 1: serializer completed 8 shifts.
- `ser_en` out 1: serializer enable.
- `busy` out 1: serializer mode. 0 = load, 1 = shift.
- `TX_OUT` out 1: serial line, idle high.
- `frame_err` out 1: one-cycle pulse on a serializer sync fault.

## Operation
States:
- IDLE
- START
- DATA
- PARITY (only with macro)
- STOP

Accept:
- `data_ready` = state is IDLE or STOP.
- Accept = `Data_Valid & data_ready`.
- In the accept cycle: `ser_en`=1, `busy`=0, so the serializer loads `P_Data` at this edge.
- Also in the accept cycle, register:
  - `par_bit` <= `(^P_Data) ^ PAR_TYP`
  - `par_en_q` <= `PAR_EN`
- Next state after accept is START.

Per-state behaviour:
- START: `TX_OUT`=0, `ser_en`=1, `busy`=1; the first shift happens at this edge. Next state: DATA; data counter cleared to 0.
- DATA: `TX_OUT`=`ser_data`, `ser_en`=1, `busy`=1. The 4-bit data counter increments each cycle. The state lasts exactly 8 cycles; the counter, not `ser_done`, is authoritative. After the 8th cycle go to PARITY if `par_en_q`, else STOP.
- PARITY: `TX_OUT`=`par_bit`, `ser_en`=0. Next state: STOP.
- STOP: `TX_OUT`=1, `ser_en`=0 unless accepting. Next state: START on accept, else IDLE.
- IDLE: `TX_OUT`=1, `ser_en`=0 unless accepting.

Other rules:
- `TX_OUT` is a combinational mux of registered sources (state, `ser_data`, `par_bit`).
- `frame_err` is a registered pulse the cycle after either of these faults:
  - the 8th DATA cycle sees `ser_done`=0;
  - `ser_done`=1 in any earlier DATA cycle.
- The frame still completes normally after a fault.
- `Data_Valid` while not ready: ignored; the source must hold it.

## Timing
- Accept at edge E0. `TX_OUT` sequence per cycle:
  - E0–E1: start bit (0).
  - E1–E9: data bits 0..7.
  - E9–E10: parity bit, if enabled.
  - Then one stop cycle.
- Frame length: 11 cycles with parity, 10 without.
- Back-to-back: an accept in the STOP cycle makes the next start bit immediately follow stop. There are no idle cycles between frames.
- Latency from accept to the first `TX_OUT` low: 1 cycle.
- Reset values: state IDLE, `TX_OUT`=1, `ser_en`=0, `busy`=0, `data_ready`=1, `frame_err`=0, `par_bit`=0, `par_en_q`=0, counter 0.
- Reset mid-frame: the next edge returns to IDLE with `TX_OUT`=1. No partial frame resumes.
- The serializer is reset independently. A stale `ser_done` is cleared by its next load.
- Reset has priority over accept in the same cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state, `par_bit` and `par_en_q` are present.
  - Frame length follows `PAR_EN`.
- Not defined:
  - PARITY state and parity registers are removed.
  - `PAR_EN`/`PAR_TYP` are ignored.
  - DATA always goes to STOP; frames are always 10 cycles.

## Test plan
- Reset, hold idle:
  - All outputs at reset values.
  - `TX_OUT`=1 for 20 cycles.
- `P_Data`=8'hA5, `PAR_EN`=1, `PAR_TYP`=0:
  - `TX_OUT` = 0,1,0,1,0,0,1,0,1,0,1 (parity 0), then 1 idle.
  - `frame_err`=0.
- `P_Data`=8'h01, `PAR_EN`=1, `PAR_TYP`=1:
  - Parity bit is 0.
  - With `PAR_TYP`=0 the parity bit is 1.
- `P_Data`=8'hFF, `PAR_EN`=0, then `Data_Valid` held for a second byte 8'h00:
  - 10-cycle frame.
  - Second start bit directly follows the stop cycle.
  - `data_ready` is high only in the IDLE/STOP cycles.
- `rst` asserted during DATA cycle 4:
  - Next cycle IDLE, `TX_OUT`=1, `ser_en`=0.
  - A new byte 8'h3C then sends correctly.
- Bench forces `ser_done` low through the 8th DATA cycle:
  - One-cycle `frame_err` pulse.
  - Stop bit still sent on schedule.
